// File: rtl/width_conv_pkg.sv
// Shared types and constants for the 8->16 byte-pair packing arbiter.
//   state_e : arbiter FSM state (IDLE, LOW, OUT), 2-bit encoded
//   BYTE_W  : width of one requester byte
//   WORD_W  : width of one packed output word
package width_conv_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder.
// Returns the first asserted request found by searching from ptr+1 upward
// and wrapping modulo NUM_REQ, so ptr itself has the lowest priority.
// Ports:
//   req  in  NUM_REQ  request vector
//   ptr  in  ID_W     index of the most recently served requester
//   any  out 1        at least one request is asserted
//   idx  out ID_W     index of the winning request (0 when any=0)
module rr_pick
  import width_conv_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  int            cand;
  logic [ID_W-1:0] cand_idx;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    any      = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand     = (int'(ptr) + k) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/width_8to16_arbiter.sv
// Shares one 8->16 byte-pair packer among NUM_REQ byte-stream requesters.
// One requester is granted per 16-bit word in round-robin order and keeps the
// grant until its second byte arrives (or the wait times out).
// Ports:
//   clk        in   1            clock, rising edge
//   rst_n      in   1            asynchronous reset, active low
//   req_valid  in   NUM_REQ      per-requester byte valid
//   req_data   in   NUM_REQ*8    requester i on [8i+7:8i]
//   req_ready  out  NUM_REQ      per-requester accept, at most one bit high
//   out_valid  out  1            packed word valid
//   out_data   out  16           {first byte, second byte}
//   out_id     out  ID_W         requester that produced out_data
//   out_ready  in   1            consumer accept
//   abort      out  1            one-cycle pulse when a pair is dropped
module width_8to16_arbiter
  import width_conv_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [WORD_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
  output logic                      abort
);

  localparam int TMR_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMR_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_LAST_I[TMR_W-1:0];

  state_e              state_q;
  logic [BYTE_W-1:0]   hi_q;
  logic [ID_W-1:0]     gnt_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [TMR_W-1:0]    timer_q;
  logic                out_valid_q;
  logic [WORD_W-1:0]   out_data_q;
  logic [ID_W-1:0]     out_id_q;
  logic                abort_q;

  logic                pick_any;
  logic [ID_W-1:0]     pick_idx;
  logic [BYTE_W-1:0]   first_byte;
  logic [BYTE_W-1:0]   second_byte;

  function automatic logic [BYTE_W-1:0] byte_of(
    input logic [NUM_REQ*BYTE_W-1:0] bus,
    input logic [ID_W-1:0]           sel
  );
    byte_of = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == sel) byte_of = bus[i*BYTE_W +: BYTE_W];
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] sel);
    onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == sel) onehot[i] = 1'b1;
    end
  endfunction

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_pick (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );

  assign first_byte  = byte_of(req_data, pick_idx);
  assign second_byte = byte_of(req_data, gnt_q);

  // The first byte is accepted in the same cycle the winner is chosen, so
  // req_ready is combinational in IDLE. It is gated with rst_n so that no
  // byte is acknowledged while the FSM is held in reset.
  always_comb begin
    req_ready = '0;
    case (state_q)
      IDLE:    if (pick_any && rst_n) req_ready = onehot(pick_idx);
      LOW:     req_ready = onehot(gnt_q);
      default: req_ready = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      gnt_q       <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            hi_q    <= first_byte;
            gnt_q   <= pick_idx;
            timer_q <= '0;
            state_q <= LOW;
          end
        end
        LOW: begin
          timer_q <= timer_q + TMR_W'(1);
          if (req_valid[gnt_q]) begin
            out_data_q  <= {hi_q, second_byte};
            out_id_q    <= gnt_q;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (TIMEOUT != 0 && timer_q == TMR_LAST) begin
            // The half-built pair is dropped; the stalled requester moves
            // to lowest priority so the others get a turn first.
            abort_q  <= 1'b1;
            rr_ptr_q <= gnt_q;
            state_q  <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            rr_ptr_q    <= gnt_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_width_8to16_arbiter.sv
module tb_width_8to16_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic [15:0]          out_data;
  logic [ID_W-1:0]      out_id;
  logic                 out_ready;
  logic                 abort;

  width_8to16_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
    .out_ready(out_ready),
    .abort    (abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  // Scoreboard of expected {id, word} in delivery order.
  logic [17:0] exp_q[$];
  logic [17:0] mon_exp;

  // Per-requester byte sources: byte plus idle cycles before it is offered.
  logic [7:0] src_mem [NUM_REQ][64];
  int         src_gap [NUM_REQ][64];
  int         head [NUM_REQ] = '{default: 0};
  int         tail [NUM_REQ] = '{default: 0};
  logic [NUM_REQ-1:0] fire;

  task automatic push_byte(input int r, input logic [7:0] d, input int g);
    src_mem[r][tail[r]] = d;
    src_gap[r][tail[r]] = g;
    tail[r]++;
  endtask

  // Source driver and output monitor: sample at negedge, drive after posedge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    fire      = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      if (out_valid && out_ready) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word: got id=%0d data=%h, required no word", out_id, out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({out_id, out_data} !== mon_exp) begin
            errors++;
            $display("FAIL word: got id=%0d data=%h, required id=%0d data=%h",
                     out_id, out_data, mon_exp[17:16], mon_exp[15:0]);
          end
        end
      end
      if (abort) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL abort_vs_valid: out_valid=%b with abort, required 0", out_valid);
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire[i] && head[i] != tail[i]) head[i]++;
        if (head[i] != tail[i] && src_gap[i][head[i]] > 0) src_gap[i][head[i]]--;
        req_valid[i]       = (head[i] != tail[i]) && (src_gap[i][head[i]] == 0);
        req_data[i*8 +: 8] = (head[i] != tail[i]) ? src_mem[i][head[i]] : 8'h00;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    exp_q.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    hs_count = 0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    #12;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready: got %b, required 0000", req_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++; $display("FAIL reset_out_data: got %h, required 0000", out_data);
    end
    checks++;
    if (out_id !== 2'd0) begin
      errors++; $display("FAIL reset_out_id: got %0d, required 0", out_id);
    end
    checks++;
    if (abort !== 1'b0) begin
      errors++; $display("FAIL reset_abort: got %b, required 0", abort);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    push_byte(0, 8'hAB, 0);
    push_byte(0, 8'hCD, 0);
    exp_q.push_back({2'd0, 16'hABCD});
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_first: req_ready=%b out_valid=%b, required 0001/0", req_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_second: req_ready=%b out_valid=%b, required 0001/0", req_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hABCD || out_id !== 2'd0) begin
      errors++; $display("FAIL single_latency: valid=%b data=%h id=%0d, required 1/abcd/0", out_valid, out_data, out_id);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pulse: out_valid=%b, required 0", out_valid);
    end
    checks++;
    if (hs_count != 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL single_count: words=%0d pending=%0d, required 1/0", hs_count, exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    int n;
    bit multi;
    do_reset();
    @(negedge clk);
    for (int r = 0; r < NUM_REQ; r++) begin
      push_byte(r, 8'(8'hA0 + r), 0);
      push_byte(r, 8'(8'hB0 + r), 0);
      exp_q.push_back({2'(r), 8'(8'hA0 + r), 8'(8'hB0 + r)});
    end
    push_byte(0, 8'hC0, 0);
    push_byte(0, 8'hD0, 0);
    exp_q.push_back({2'd0, 16'hC0D0});
    n = 0;
    multi = 1'b0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      if ($countones(req_ready) > 1) multi = 1'b1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_drain: pending=%0d, required 0", exp_q.size());
    end
    checks++;
    if (multi) begin
      errors++; $display("FAIL rr_onehot: multiple req_ready seen, required at most one");
    end
    checks++;
    if (n > 16) begin
      errors++; $display("FAIL rr_throughput: %0d cycles for 5 words, required <= 16", n);
    end
  endtask

  task automatic test_lock();
    int n;
    do_reset();
    @(negedge clk);
    push_byte(1, 8'h11, 0);
    push_byte(1, 8'h44, 3);
    push_byte(2, 8'h22, 1);
    push_byte(2, 8'h33, 0);
    exp_q.push_back({2'd1, 16'h1144});
    exp_q.push_back({2'd2, 16'h2233});
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL lock_grant: req_ready=%b, required 0010", req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || req_valid[2] !== 1'b1 || req_valid[1] !== 1'b0) begin
      errors++; $display("FAIL lock_hold: req_ready=%b req_valid=%b, required 0010 with req2 waiting", req_ready, req_valid);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL lock_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    @(negedge clk);
    out_ready = 1'b0;
    push_byte(0, 8'h12, 0);
    push_byte(0, 8'h34, 0);
    push_byte(1, 8'h56, 0);
    push_byte(1, 8'h78, 0);
    exp_q.push_back({2'd0, 16'h1234});
    exp_q.push_back({2'd1, 16'h5678});
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_arrive: out_valid=%b, required 1", out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_id !== 2'd0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b data=%h id=%0d req_ready=%b, required 1/1234/0/0000",
                 k, out_valid, out_data, out_id, req_ready);
      end
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || hs_count != 2) begin
      errors++; $display("FAIL stall_once: pending=%0d words=%0d, required 0/2", exp_q.size(), hs_count);
    end
  endtask

  task automatic test_timeout();
    int n;
    int low_cnt;
    bit seen_abort;
    bit seen_ov;
    do_reset();
    @(negedge clk);
    push_byte(1, 8'h01, 0);
    push_byte(1, 8'h02, 0);
    exp_q.push_back({2'd1, 16'h0102});
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    push_byte(3, 8'h5A, 0);
    low_cnt = 0;
    seen_abort = 1'b0;
    seen_ov = 1'b0;
    n = 0;
    while (!seen_abort && n < 40) begin
      @(negedge clk);
      if (abort === 1'b1) seen_abort = 1'b1;
      else if (req_ready === 4'b1000 && req_valid[3] === 1'b0) low_cnt++;
      if (out_valid === 1'b1) seen_ov = 1'b1;
      n++;
    end
    checks++;
    if (!seen_abort || low_cnt != TIMEOUT) begin
      errors++; $display("FAIL timeout_len: abort_seen=%b low_cycles=%0d, required 1/%0d", seen_abort, low_cnt, TIMEOUT);
    end
    checks++;
    if (seen_ov) begin
      errors++; $display("FAIL timeout_noword: out_valid seen=1, required 0");
    end
    @(negedge clk);
    checks++;
    if (abort !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: abort=%b, required 0", abort);
    end
    push_byte(2, 8'h21, 0);
    push_byte(2, 8'h22, 0);
    push_byte(0, 8'h0F, 0);
    push_byte(0, 8'hF0, 0);
    exp_q.push_back({2'd0, 16'h0FF0});
    exp_q.push_back({2'd2, 16'h2122});
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL timeout_next: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    @(negedge clk);
    push_byte(1, 8'h9A, 0);
    push_byte(1, 8'hBC, 0);
    exp_q.push_back({2'd1, 16'h9ABC});
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    push_byte(2, 8'h77, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100 || out_data !== 16'h9ABC) begin
      errors++; $display("FAIL midrst_pre: req_ready=%b out_data=%h, required 0100/9abc", req_ready, out_data);
    end
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    #1;
    checks++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b0 || out_data !== 16'h0000 ||
        out_id !== 2'd0 || abort !== 1'b0) begin
      errors++;
      $display("FAIL midrst_now: req_ready=%b valid=%b data=%h id=%0d abort=%b, required all 0",
               req_ready, out_valid, out_data, out_id, abort);
    end
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    push_byte(0, 8'hC3, 0);
    push_byte(0, 8'h3C, 0);
    push_byte(3, 8'h5C, 0);
    push_byte(3, 8'hC5, 0);
    exp_q.push_back({2'd0, 16'hC33C});
    exp_q.push_back({2'd3, 16'h5CC5});
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL midrst_after: pending=%0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_stall();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
